// File: rtl/arith_multiply_pkg.sv
// Shared types for the shift-add multiplier: operand signedness selector,
// engine state encoding and a counter-width helper.
package arith_multiply_pkg;

    // Signedness selector, same convention as the operand extender.
    typedef enum logic {
        ARITH_UNSIGNED = 1'b0,
        ARITH_SIGNED   = 1'b1
    } arith_signed_unsigned_t;

    // Multiplier engine states.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2
    } arith_multiply_state_t;

    // Iteration counter width: must be able to hold WIDTH.
    function automatic int unsigned mul_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/arith_multiply_negate.sv
// Conditional two's-complement: o_y = i_neg ? -i_x : i_x (modulo 2^WIDTH).
// Ports:
//   i_neg  negate request
//   i_x    input value
//   o_y    result (combinational)
module arith_multiply_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_neg ? (~i_x + WIDTH'(1)) : i_x;

endmodule

// File: rtl/arith_multiply.sv
// Multi-cycle signed/unsigned shift-add multiplier with HI/LO registers.
// One radix-2 step per RUN cycle on unsigned magnitudes, followed by a FIX
// cycle that applies the result sign and writes HI/LO.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_sign            signed/unsigned select, sampled with i_start
//   i_start           multiply request, accepted only when idle
//   i_a, i_b          multiplicand / multiplier, sampled with i_start
//   i_flush           abort in-flight multiply (beats everything but reset)
//   i_mthi, i_mtlo    direct HI/LO write from i_wdata, idle only
//   i_wdata           MTHI/MTLO data
//   o_busy            high while in RUN or FIX
//   o_done            one-cycle pulse when HI/LO first show a new product
//   o_hi, o_lo        architectural HI/LO registers
module arith_multiply
    import arith_multiply_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  arith_signed_unsigned_t i_sign,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    input  logic                   i_flush,
    input  logic                   i_mthi,
    input  logic                   i_mtlo,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [WIDTH-1:0]       o_hi,
    output logic [WIDTH-1:0]       o_lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = mul_cnt_width(WIDTH);

    arith_multiply_state_t r_state;
    arith_multiply_state_t w_state_next;

    logic [WIDTH-1:0] r_mcand;
    logic [PW:0]      r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_step;
    logic             w_fix;
    logic             w_mt_ok;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_upper;
    logic [PW:0]      w_acc_step;
    logic [PW-1:0]    w_prod;

    // Operand magnitudes and final sign fixup.
    assign w_signed = (i_sign == ARITH_SIGNED);
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];

    arith_multiply_negate #(.WIDTH(WIDTH)) u_neg_a (
        .i_neg (w_a_neg),
        .i_x   (i_a),
        .o_y   (w_a_mag)
    );

    arith_multiply_negate #(.WIDTH(WIDTH)) u_neg_b (
        .i_neg (w_b_neg),
        .i_x   (i_b),
        .o_y   (w_b_mag)
    );

    arith_multiply_negate #(.WIDTH(PW)) u_neg_p (
        .i_neg (r_neg),
        .i_x   (r_acc[PW-1:0]),
        .o_y   (w_prod)
    );

    // One radix-2 step: the multiplier lives in the low half of the
    // accumulator and is consumed LSB-first as the product shifts in.
    assign w_upper    = r_acc[PW:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_step = {1'b0, w_upper, r_acc[WIDTH-1:1]};

    // Next-state and action decode; flush overrides every action.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        w_mt_ok      = 1'b0;
        if (i_flush) begin
            w_state_next = MUL_IDLE;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    w_mt_ok = 1'b1;
                    if (i_start) begin
                        w_accept     = 1'b1;
                        w_state_next = MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_next = MUL_FIX;
                    end
                end
                MUL_FIX: begin
                    w_fix        = 1'b1;
                    w_state_next = MUL_IDLE;
                end
                default: begin
                    w_state_next = MUL_IDLE;
                end
            endcase
        end
    end

    // State register with registered busy flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MUL_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != MUL_IDLE);
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_mcand <= w_a_mag;
                r_acc   <= {{(WIDTH+1){1'b0}}, w_b_mag};
                r_cnt   <= '0;
                r_neg   <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            end else if (w_step) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fix) begin
                r_hi <= w_prod[PW-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else begin
                if (w_mt_ok && i_mthi) r_hi <= i_wdata;
                if (w_mt_ok && i_mtlo) r_lo <= i_wdata;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: doc/arith_multiply.md
# Arith_multiply

Multi-cycle signed/unsigned integer multiplier that produces a 2×WIDTH product into HI/LO registers for MULT/MULTU. It sits in the execute stage beside the ALU and consumes register operands and the `Arith_SignedUnsigned_T` selector from decode. It uses the same signedness convention as the operand extender. It is a shift-add engine with a start/busy/done handshake, a pipeline flush, and MTHI/MTLO writes.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2×WIDTH, with HI as the upper half and LO as the lower half.

Ports:
- ctrl  input  `Util_Control_T`  carries the clock (`Util_Control_Clock(ctrl)`) and reset (`Util_Control_Reset(ctrl)`). There is one clock. Reset is synchronous and active-high.
- sign  input  `Arith_SignedUnsigned_T`  selects signed or unsigned operation; it is sampled with start.
- start  input  1  requests a multiply; it is accepted only in IDLE.
- a, b  input  WIDTH  multiplicand and multiplier; they are sampled with start.
- flush  input  1  aborts an in-flight multiply.
- mthi, mtlo  input  1  request a direct write of HI or LO from wdata.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while the engine is in RUN or FIX.
- done  output  1  one-cycle pulse; it is high in the cycle when hi/lo first show a new product.
- hi, lo  output  WIDTH  architectural HI/LO registers.

## Operation
- The state machine has three states: IDLE, RUN and FIX.
  - IDLE→RUN on start.
  - RUN→FIX when the iteration count reaches WIDTH.
  - FIX→IDLE always.
  - RUN or FIX→IDLE on flush.
- On accept, the block latches:
  - operand magnitudes: for signed operation |a| and |b| as WIDTH-bit unsigned values (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits); for unsigned operation the raw values;
  - neg = sign & (a[MSB] ^ b[MSB]).
- Each RUN cycle performs one radix-2 step:
  - if multiplier LSB = 1, add the multiplicand to the upper half of the 2W+1-bit accumulator;
  - shift the accumulator right by 1.
  - After WIDTH steps the accumulator holds the unsigned product.
- FIX writes {hi, lo} = neg ? −product : product, computed modulo 2^(2W).
- The product is exact for all inputs, including signed (−2^(W−1))².
- start while busy is ignored: no queuing and no error.
- start in the same cycle that done is high is accepted, because the state is IDLE.
- mthi/mtlo:
  - They write only in IDLE, at the next edge. They are ignored while busy.
  - If start and mthi/mtlo occur together in IDLE, both take effect. The later product overwrites HI/LO.
- flush:
  - It wins over every other action except reset.
  - In RUN or FIX, the next edge returns to IDLE with no HI/LO write and no done pulse.
  - In IDLE it is a no-op, and a start in the same cycle is dropped.
- Reset puts the state in IDLE and sets hi = lo = 0, busy = 0 and done = 0. It applies mid-operation with the same result. Reset beats flush, start and mthi/mtlo.

## Timing
- Start is accepted at edge k. RUN steps occur at edges k+1 … k+WIDTH. FIX writes HI/LO at edge k+WIDTH+1.
- busy is high in the cycles after edges k … k+WIDTH and low after edge k+WIDTH+1.
- done is high in exactly the one cycle after edge k+WIDTH+1, and hi/lo are valid in that cycle. The start-to-done latency is WIDTH+1 edges.
- The next start can be accepted at edge k+WIDTH+2, which gives a back-to-back throughput of one product every WIDTH+2 cycles.
- MTHI/MTLO are visible one cycle after the request edge.
- All outputs are registered, with no combinational path from inputs.

## Structure
- The shared header (Data/Arith) holds:
  - state encoding macros `Arith_multiply_Idle`, `Arith_multiply_Run` and `Arith_multiply_Fix`;
  - the state type macro `Arith_multiply_State_T`.
- The block reuses the existing SignedUnsigned and Control headers; no new typedef is needed for sign or ctrl.
- Submodule `Arith_negate` (parameter WIDTH, combinational conditional two's-complement) is instantiated three times: operand a magnitude, operand b magnitude, and 2W product fixup.
- The iteration counter is $clog2(WIDTH+1) bits wide.

## Test plan
All scenarios use WIDTH=4 unless noted.
- Signed multiply: a=4'ha (−6), b=4'h5, sign=Signed → done 5 edges after accept; hi=4'he, lo=4'h2 (−30). busy is high for 5 cycles before done, and done lasts 1 cycle.
- Unsigned multiply: same operands, sign=Unsigned → hi=4'h3, lo=4'h2 (50).
- Signed corner cases:
  - a=b=4'h8 → hi=4'h4, lo=4'h0 (64).
  - a=4'h8, b=4'h1 → hi=4'hf, lo=4'h8.
  - a=0 with any b → 0.
- Unsigned maximum: a=b=4'hf → hi=4'he, lo=4'h1.
- Flush, reset and busy handling:
  - flush at RUN step 2 → busy drops next cycle, done never pulses, and HI/LO keep their prior values.
  - Reset mid-RUN → hi=lo=0 and idle on the next cycle.
  - start while busy is ignored.
- MTHI/MTLO:
  - mthi wdata=4'h7 in IDLE → hi=4'h7 next cycle.
  - mtlo while busy → ignored.
  - mthi together with start → hi=4'h7, then overwritten at done.
  - WIDTH=32 regression: 0x80000000×0x80000000, signed → hi=0x40000000, lo=0.
